fp_add_pipe: RTL

//  Pipelined, parametrised IEEE-style floating add/subtract: out = a + (negate ? -b : b).

---
 rtl/fp_add_pipe_if.sv | 32 +++
 rtl/fp_add_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe_if.sv
// Handshake bundle for the pipelined float adder: operand side and result side.
interface fp_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             negate;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       out_flags;

  // producer of operands / consumer of results
  modport master (
    output in_valid, a, b, negate, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag, out_flags
  );

  // the adder itself
  modport slave (
    input  in_valid, a, b, negate, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag, out_flags
  );
endinterface

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined float add/subtract, out = a + (negate ? -b : b).
// S1 unpack/align, S2 mantissa add, S3 normalise/pack. Denormals flush to zero.
// Optional macro FP_ADD_ROUND_EN: round-to-nearest-even in S3 (default truncates).
// Flags are {nan, overflow, underflow}, per result.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  fp_add_pipe_if.slave s_bus
);
  localparam int          W      = 1 + EXP_W + MAN_W;
  localparam int          MX     = MAN_W + 4;        // {hidden, man, g, r, s}
  localparam int          XW     = EXP_W + 2;        // signed exponent work width
  localparam int          CW     = $clog2(MX + 1);
  localparam int unsigned SH_MAX = MAN_W + 3;
  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic signed [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);

  // ---------------------------------------------------------------- control
  logic [3:1] r_vld_pipe;
  logic       w_adv;

  assign w_adv           = !r_vld_pipe[3] | s_bus.out_ready;
  assign s_bus.in_ready  = w_adv;
  assign s_bus.out_valid = r_vld_pipe[3];

  // valid shift register; whole pipe steps together, reset drops in-flight ops
  always_ff @(posedge clk) begin
    if (reset)      r_vld_pipe <= '0;
    else if (w_adv) r_vld_pipe <= {r_vld_pipe[2:1], s_bus.in_valid};
  end

  // ---------------------------------------------------------------- S1 unpack/align
  logic             w_a_sgn, w_b_sgn;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_man, w_b_man;
  logic             w_a_max, w_b_max, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic             w_sp, w_sp_nan;
  logic [W-1:0]     w_sp_word;
  logic [MX-1:0]    w_a_m, w_b_m, w_big_m, w_sml_m, w_sml_al;
  logic             w_swap, w_big_sgn, w_sml_sgn, w_lost;
  logic [EXP_W-1:0] w_big_exp, w_sml_exp, w_diff;

  assign w_a_sgn = s_bus.a[W-1];
  assign w_a_exp = s_bus.a[W-2:MAN_W];
  assign w_a_man = s_bus.a[MAN_W-1:0];
  assign w_b_sgn = s_bus.b[W-1] ^ s_bus.negate;   // negate applied before the swap
  assign w_b_exp = s_bus.b[W-2:MAN_W];
  assign w_b_man = s_bus.b[MAN_W-1:0];

  assign w_a_max  = (w_a_exp == EXP_ONES);
  assign w_b_max  = (w_b_exp == EXP_ONES);
  assign w_a_nan  = w_a_max & (|w_a_man);
  assign w_b_nan  = w_b_max & (|w_b_man);
  assign w_a_inf  = w_a_max & ~(|w_a_man);
  assign w_b_inf  = w_b_max & ~(|w_b_man);
  assign w_sp     = w_a_max | w_b_max;
  assign w_sp_nan = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_a_sgn ^ w_b_sgn));
  assign w_sp_word = w_sp_nan ? {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}} :
                     w_a_inf  ? {w_a_sgn, EXP_ONES, {MAN_W{1'b0}}} :
                                {w_b_sgn, EXP_ONES, {MAN_W{1'b0}}};

  // exponent field 0 means zero: no hidden bit, mantissa discarded
  assign w_a_m = (w_a_exp != '0) ? {1'b1, w_a_man, 3'b000} : '0;
  assign w_b_m = (w_b_exp != '0) ? {1'b1, w_b_man, 3'b000} : '0;

  assign w_swap    = (w_b_exp > w_a_exp);
  assign w_big_exp = w_swap ? w_b_exp : w_a_exp;
  assign w_sml_exp = w_swap ? w_a_exp : w_b_exp;
  assign w_big_m   = w_swap ? w_b_m   : w_a_m;
  assign w_sml_m   = w_swap ? w_a_m   : w_b_m;
  assign w_big_sgn = w_swap ? w_b_sgn : w_a_sgn;
  assign w_sml_sgn = w_swap ? w_a_sgn : w_b_sgn;
  assign w_diff    = w_big_exp - w_sml_exp;

  // right-shift the small mantissa, folding every lost bit into sticky
  always_comb begin
    w_sml_al = '0;
    w_lost   = 1'b0;
    if (32'(w_diff) >= SH_MAX) begin
      w_sml_al = {{(MX-1){1'b0}}, |w_sml_m};
    end else begin
      w_lost   = |(w_sml_m & ~({MX{1'b1}} << w_diff));
      w_sml_al = (w_sml_m >> w_diff) | {{(MX-1){1'b0}}, w_lost};
    end
  end

  logic             r1_big_sgn, r1_sml_sgn, r1_sp, r1_sp_nan;
  logic [EXP_W-1:0] r1_exp;
  logic [MX-1:0]    r1_big_m, r1_sml_m;
  logic [W-1:0]     r1_sp_word;
  logic [TAG_W-1:0] r1_tag;

  // S1 register
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_big_sgn <= w_big_sgn;
      r1_sml_sgn <= w_sml_sgn;
      r1_exp     <= w_big_exp;
      r1_big_m   <= w_big_m;
      r1_sml_m   <= w_sml_al;
      r1_sp      <= w_sp;
      r1_sp_nan  <= w_sp_nan;
      r1_sp_word <= w_sp_word;
      r1_tag     <= s_bus.in_tag;
    end
  end

  // ---------------------------------------------------------------- S2 add
  logic          w_sub, w_neg, w_sgn2;
  logic [MX:0]   w_mag;

  assign w_sub  = r1_big_sgn ^ r1_sml_sgn;
  assign w_neg  = w_sub & (r1_sml_m > r1_big_m);   // equal exps can still go negative
  assign w_mag  = !w_sub ? ({1'b0, r1_big_m} + {1'b0, r1_sml_m}) :
                  w_neg  ? ({1'b0, r1_sml_m} - {1'b0, r1_big_m}) :
                           ({1'b0, r1_big_m} - {1'b0, r1_sml_m});
  assign w_sgn2 = (w_mag == '0) ? 1'b0 : (r1_big_sgn ^ w_neg);

  logic             r2_sgn, r2_sp, r2_sp_nan;
  logic [EXP_W-1:0] r2_exp;
  logic [MX:0]      r2_mag;
  logic [W-1:0]     r2_sp_word;
  logic [TAG_W-1:0] r2_tag;

  // S2 register
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r2_sgn     <= w_sgn2;
      r2_exp     <= r1_exp;
      r2_mag     <= w_mag;
      r2_sp      <= r1_sp;
      r2_sp_nan  <= r1_sp_nan;
      r2_sp_word <= r1_sp_word;
      r2_tag     <= r1_tag;
    end
  end

  // ---------------------------------------------------------------- S3 normalise/pack
  logic [CW-1:0]    w_clz;
  logic             w_found;
  logic [MX-1:0]    w_norm;
  logic [XW-1:0]    w_exp_ext, w_exp_n, w_exp_f;
  logic [MAN_W-1:0] w_man_f;
  logic [W-1:0]     w_res;
  logic [2:0]       w_flags;

  assign w_exp_ext = {2'b00, r2_exp};

  // leading-zero count below the carry bit
  always_comb begin
    w_clz   = '0;
    w_found = 1'b0;
    for (int i = MX - 1; i >= 0; i--) begin
      if (!w_found && r2_mag[i]) begin
        w_clz   = CW'(MX - 1 - i);
        w_found = 1'b1;
      end
    end
  end

  // carry shifts right one, otherwise shift left by clz
  always_comb begin
    if (r2_mag[MX]) begin
      w_norm  = {r2_mag[MX:2], r2_mag[1] | r2_mag[0]};
      w_exp_n = w_exp_ext + XW'(1);
    end else begin
      w_norm  = r2_mag[MX-1:0] << w_clz;
      w_exp_n = w_exp_ext - XW'(w_clz);
    end
  end

`ifdef FP_ADD_ROUND_EN
  logic             w_rnd_up;
  logic [MAN_W+1:0] w_mant_r;

  // nearest-even from guard/round/sticky; a carry-out renormalises
  always_comb begin
    w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant_r = {1'b0, w_norm[MX-1:3]} + (MAN_W+2)'(w_rnd_up);
    if (w_mant_r[MAN_W+1]) begin
      w_man_f = w_mant_r[MAN_W:1];
      w_exp_f = w_exp_n + XW'(1);
    end else begin
      w_man_f = w_mant_r[MAN_W-1:0];
      w_exp_f = w_exp_n;
    end
  end
`else
  logic w_unused_grs;
  assign w_unused_grs = ^w_norm[2:0];

  // truncation: guard/round/sticky dropped
  always_comb begin
    w_man_f = w_norm[MX-2:3];
    w_exp_f = w_exp_n;
  end
`endif

  // final selection: specials, exact zero, overflow, underflow, normal
  always_comb begin
    w_res   = {r2_sgn, w_exp_f[EXP_W-1:0], w_man_f};
    w_flags = 3'b000;
    if (r2_sp) begin
      w_res   = r2_sp_word;
      w_flags = {r2_sp_nan, 2'b00};
    end else if (r2_mag == '0) begin
      w_res   = '0;
    end else if ($signed(w_exp_f) >= EXP_TOP) begin
      w_res   = {r2_sgn, EXP_ONES, {MAN_W{1'b0}}};
      w_flags = 3'b010;
    end else if (w_exp_f[XW-1] || (w_exp_f == '0)) begin
      w_res   = '0;
      w_flags = 3'b001;
    end
  end

  logic [W-1:0]     r_out;
  logic [TAG_W-1:0] r_out_tag;
  logic [2:0]       r_out_flags;

  // output register; holds while the consumer stalls or a bubble passes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_out_tag   <= '0;
      r_out_flags <= '0;
    end else if (w_adv && r_vld_pipe[2]) begin
      r_out       <= w_res;
      r_out_tag   <= r2_tag;
      r_out_flags <= w_flags;
    end
  end

  assign s_bus.out       = r_out;
  assign s_bus.out_tag   = r_out_tag;
  assign s_bus.out_flags = r_out_flags;
endmodule
